// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package imem_pkg;

    // Controller states: power-up clear, normal fetch, program streaming, tail clear.
    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2,
        FILL = 2'd3
    } imem_state_e;

    localparam logic [15:0] OP_NOP  = 16'h0000;
    localparam logic [15:0] OP_HALT = 16'hFFFF;

    // Byte address to instruction-word index (instructions are two bytes wide).
    function automatic logic [31:0] index_of(input logic [31:0] addr);
        return addr >> 1;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Plain storage array: one synchronous write port, one synchronous read port.
// Contents are not reset; the controller clears them after reset instead.
module imem_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned PTR_W  = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port; the read register holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_instruction_mem.sv
// Loadable, synchronous-read instruction memory with fetch fault flagging.
// Memory is cleared to FILL_WORD after reset and behind every loaded program.
module prog_instruction_mem
    import imem_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       DEPTH     = 256,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(OP_NOP)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_req,
    input  logic [ADDR_W-1:0]          fetch_addr,
    output logic [DATA_W-1:0]          instr,
    output logic                       instr_valid,
    output logic                       addr_fault,
    input  logic                       load_start,
    input  logic                       ld_valid,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       ld_last,
    output logic                       ld_ready,
    output logic                       busy,
    output logic                       load_ovf,
    output logic [$clog2(DEPTH+1)-1:0] prog_len
);

    localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      LEN_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    imem_state_e       state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              load_ovf_q, load_ovf_d;
    logic [LEN_W-1:0]  prog_len_q, prog_len_d;
    logic              instr_valid_q, addr_fault_q, fill_sel_q;

    logic              wr_en;
    logic [PTR_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [31:0]       fetch_idx;
    logic              fetch_misaligned, fetch_oor, fetch_fault, fetch_accept, rd_en;
    logic [PTR_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;

    // Fetch decode: load_start has priority, so a same-cycle fetch is dropped.
    assign fetch_idx        = index_of(32'(fetch_addr));
    assign fetch_misaligned = fetch_addr[0];
    assign fetch_oor        = (fetch_idx >= 32'(DEPTH));
    assign fetch_fault      = fetch_misaligned | fetch_oor;
    assign fetch_accept     = (state_q == RUN) && fetch_req && !load_start;
    assign rd_en            = fetch_accept && !fetch_fault;
    assign rd_addr          = PTR_W'(fetch_idx);

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Next-state, write-port and load bookkeeping logic.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        load_ovf_d = load_ovf_q;
        prog_len_d = prog_len_q;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr_q;
        wr_data    = FILL_WORD;
        unique case (state_q)
            INIT, FILL: begin
                wr_en = 1'b1;
                if (wr_ptr_q == LAST) begin
                    state_d  = RUN;
                    wr_ptr_d = '0;
                end else begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d    = LOAD;
                    wr_ptr_d   = '0;
                    load_ovf_d = 1'b0;
                    prog_len_d = '0;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    wr_en      = 1'b1;
                    wr_data    = ld_data;
                    prog_len_d = prog_len_q + 1'b1;
                    if (ld_last) begin
                        // Clear the tail so words of an older program never leak through.
                        if (wr_ptr_q != LAST) begin
                            state_d  = FILL;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end else begin
                            state_d  = RUN;
                            wr_ptr_d = '0;
                        end
                    end else if (wr_ptr_q == LAST) begin
                        // Stream ran past the end: keep the last word, flag and stop.
                        state_d    = RUN;
                        wr_ptr_d   = '0;
                        load_ovf_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = INIT;
                wr_ptr_d = '0;
            end
        endcase
    end

    // Controller state register; reset restarts the full memory clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            wr_ptr_q   <= '0;
            load_ovf_q <= 1'b0;
            prog_len_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            load_ovf_q <= load_ovf_d;
            prog_len_q <= prog_len_d;
        end
    end

    // Fetch response registers, aligned with the array's one-cycle read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid_q <= 1'b0;
            addr_fault_q  <= 1'b0;
            fill_sel_q    <= 1'b1;
        end else begin
            instr_valid_q <= fetch_accept;
            addr_fault_q  <= fetch_accept && fetch_fault;
            if (fetch_accept) begin
                fill_sel_q <= fetch_fault;
            end
        end
    end

    // Faulted fetches show FILL_WORD; otherwise the held array read data.
    assign instr       = fill_sel_q ? FILL_WORD : rd_data;
    assign instr_valid = instr_valid_q;
    assign addr_fault  = addr_fault_q;
    assign ld_ready    = (state_q == LOAD);
    assign busy        = (state_q != RUN);
    assign load_ovf    = load_ovf_q;
    assign prog_len    = prog_len_q;

endmodule

// File: tb/tb_prog_instruction_mem.sv
// Directed testbench for prog_instruction_mem with DEPTH=256, FILL_WORD=0.
module tb_prog_instruction_mem;

    localparam logic [15:0] FILL = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = 16'h0000;
    logic        load_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_data = 16'h0000;
    logic        ld_last = 1'b0;
    logic [15:0] instr;
    logic        instr_valid, addr_fault, ld_ready, busy, load_ovf;
    logic [8:0]  prog_len;

    int checks = 0;
    int errors = 0;

    prog_instruction_mem #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .DEPTH     (256),
        .FILL_WORD (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .addr_fault  (addr_fault),
        .load_start  (load_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .busy        (busy),
        .load_ovf    (load_ovf),
        .prog_len    (prog_len)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // All tasks start and end just after a falling edge.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic fetch1(input logic [15:0] a, output logic v, output logic f, output logic [15:0] ins);
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(negedge clk);
        fetch_req  = 1'b0;
        v   = instr_valid;
        f   = addr_fault;
        ins = instr;
    endtask

    task automatic test_reset();
        int cnt;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b want 0", addr_fault); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready got %b want 0", ld_ready); end
        checks++; if (load_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", load_ovf); end
        checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL rst_len got %0d want 0", prog_len); end
        checks++; if (instr !== FILL) begin errors++; $display("FAIL rst_instr got %h want %h", instr, FILL); end
        rst_n = 1'b1;
        count_busy(cnt);
        checks++; if (cnt != 256) begin errors++; $display("FAIL init_cycles got %0d want 256", cnt); end
    endtask

    task automatic test_first_fetch();
        logic v, f;
        logic [15:0] ins;
        fetch1(16'h0000, v, f, ins);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL ff_valid got %b want 1", v); end
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL ff_fault got %b want 0", f); end
        checks++; if (ins !== 16'h0000) begin errors++; $display("FAIL ff_instr got %h want 0000", ins); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ff_pulse got %b want 0", instr_valid); end
    endtask

    task automatic test_load_basic();
        int cnt;
        logic [15:0] d [3] = '{16'h0120, 16'h0121, 16'h23FF};
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL ld_ready got %b want 1", ld_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ld_busy got %b want 1", busy); end
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = d[i];
            ld_last  = (i == 2);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        checks++; if (prog_len !== 9'd3) begin errors++; $display("FAIL ld_len got %0d want 3", prog_len); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL fill_ld_ready got %b want 0", ld_ready); end
        count_busy(cnt);
        checks++; if (cnt != 253) begin errors++; $display("FAIL fill_cycles got %0d want 253", cnt); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a   [4] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
        logic [15:0] exp [4] = '{16'h0120, 16'h0121, 16'h23FF, 16'h0000};
        fetch_req  = 1'b1;
        fetch_addr = a[0];
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++; if (instr_valid !== 1'b1 || addr_fault !== 1'b0 || instr !== exp[i-1]) begin
                errors++;
                $display("FAIL b2b_%0d got v=%b f=%b %h want v=1 f=0 %h", i-1, instr_valid, addr_fault, instr, exp[i-1]);
            end
            if (i < 4) fetch_addr = a[i];
            else       fetch_req  = 1'b0;
        end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || instr !== 16'h0000) begin
            errors++; $display("FAIL b2b_hold got v=%b %h want v=0 0000", instr_valid, instr);
        end
    endtask

    task automatic test_boundary();
        logic v, f;
        logic [15:0] ins;
        fetch1(16'h0000, v, f, ins);
        checks++; if (ins !== 16'h0120 || f !== 1'b0) begin errors++; $display("FAIL bnd_w0 got f=%b %h want f=0 0120", f, ins); end
        fetch1(16'h0003, v, f, ins);
        checks++; if (v !== 1'b1 || f !== 1'b1 || ins !== FILL) begin errors++; $display("FAIL misalign got v=%b f=%b %h want v=1 f=1 %h", v, f, ins, FILL); end
        fetch1(16'h0002, v, f, ins);
        checks++; if (ins !== 16'h0121 || f !== 1'b0) begin errors++; $display("FAIL bnd_w1 got f=%b %h want f=0 0121", f, ins); end
        fetch1(16'h0200, v, f, ins);
        checks++; if (v !== 1'b1 || f !== 1'b1 || ins !== FILL) begin errors++; $display("FAIL oor256 got v=%b f=%b %h want v=1 f=1 %h", v, f, ins, FILL); end
        fetch1(16'h01FE, v, f, ins);
        checks++; if (v !== 1'b1 || f !== 1'b0 || ins !== 16'h0000) begin errors++; $display("FAIL idx255 got v=%b f=%b %h want v=1 f=0 0000", v, f, ins); end
    endtask

    task automatic test_overflow();
        int cnt;
        logic v, f;
        logic [15:0] ins;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 257; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'(16'h1000 + i);
            @(negedge clk);
            if (i == 254) begin
                checks++; if (ld_ready !== 1'b1 || load_ovf !== 1'b0) begin errors++; $display("FAIL ovf_pre got rdy=%b ovf=%b want rdy=1 ovf=0", ld_ready, load_ovf); end
            end
            if (i == 255) begin
                checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b want 0", ld_ready); end
                checks++; if (load_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", load_ovf); end
                checks++; if (prog_len !== 9'd256) begin errors++; $display("FAIL ovf_len got %0d want 256", prog_len); end
            end
        end
        ld_valid = 1'b0;
        checks++; if (prog_len !== 9'd256 || busy !== 1'b0) begin errors++; $display("FAIL ovf_after got len=%0d busy=%b want len=256 busy=0", prog_len, busy); end
        fetch1(16'h01FE, v, f, ins);
        checks++; if (ins !== 16'h10FF || f !== 1'b0) begin errors++; $display("FAIL ovf_w255 got f=%b %h want f=0 10FF", f, ins); end
        fetch1(16'h0000, v, f, ins);
        checks++; if (ins !== 16'h1000) begin errors++; $display("FAIL ovf_w0 got %h want 1000", ins); end
        fetch1(16'h00FE, v, f, ins);
        checks++; if (ins !== 16'h107F) begin errors++; $display("FAIL ovf_w127 got %h want 107F", ins); end
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        checks++; if (load_ovf !== 1'b0 || prog_len !== 9'd0 || ld_ready !== 1'b1) begin
            errors++; $display("FAIL ovf_clear got ovf=%b len=%0d rdy=%b want ovf=0 len=0 rdy=1", load_ovf, prog_len, ld_ready);
        end
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        ld_data  = 16'hFFFF;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        checks++; if (prog_len !== 9'd1) begin errors++; $display("FAIL one_len got %0d want 1", prog_len); end
        count_busy(cnt);
        checks++; if (cnt != 255) begin errors++; $display("FAIL one_fill got %0d want 255", cnt); end
        fetch1(16'h0002, v, f, ins);
        checks++; if (ins !== 16'h0000) begin errors++; $display("FAIL stale_w1 got %h want 0000", ins); end
        fetch1(16'h0000, v, f, ins);
        checks++; if (ins !== 16'hFFFF) begin errors++; $display("FAIL halt_w0 got %h want FFFF", ins); end
    endtask

    task automatic test_same_cycle_and_reset();
        int cnt;
        logic v, f;
        logic [15:0] ins;
        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 16'h0000;
        @(negedge clk);
        load_start = 1'b0;
        fetch_req  = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL same_valid got %b want 0", instr_valid); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL same_ready got %b want 1", ld_ready); end
        ld_valid = 1'b1; ld_data = 16'hAAAA;
        @(negedge clk);
        ld_data = 16'h5555;
        @(negedge clk);
        ld_valid = 1'b0;
        checks++; if (prog_len !== 9'd2 || ld_ready !== 1'b1) begin errors++; $display("FAIL mid_load got len=%0d rdy=%b want len=2 rdy=1", prog_len, ld_ready); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || prog_len !== 9'd0 || ld_ready !== 1'b0) begin
            errors++; $display("FAIL abort got busy=%b len=%0d rdy=%b want busy=1 len=0 rdy=0", busy, prog_len, ld_ready);
        end
        rst_n = 1'b1;
        count_busy(cnt);
        checks++; if (cnt != 256) begin errors++; $display("FAIL reinit_cycles got %0d want 256", cnt); end
        fetch1(16'h0000, v, f, ins);
        checks++; if (v !== 1'b1 || f !== 1'b0 || ins !== 16'h0000) begin errors++; $display("FAIL reinit_w0 got v=%b f=%b %h want v=1 f=0 0000", v, f, ins); end
        checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL reinit_len got %0d want 0", prog_len); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_load_basic();
        test_back_to_back();
        test_boundary();
        test_overflow();
        test_same_cycle_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
